ps2_scancode_decoder: RTL and testbench

Consumes the byte stream from the PS/2 receiver (one Set-2 scan code byte per strobe) and turns it into key events. It resolves the E0 (extended), F0 (break) and E1 (Pause) prefixes, tracks modifier state and produces an ASCII code for printable keys. It sits directly downstream of the PS/2 frame receiver and upstream of any keyboard consumer (display, UART echo, debug LEDs).

---
 rtl/ps2_scancode_decoder.sv | 176 +++++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: turns a Set-2 scan code byte stream into key events with modifiers and ASCII.
module ps2_scancode_decoder #(
  parameter int TIMEOUT_CYCLES = 2500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_data_en,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_break,
  output logic [7:0] ascii,
  output logic [3:0] mods,
  output logic       proto_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0, PAUSE} state_t;

  state_t        state_q, state_d;
  logic [2:0]    pcnt_q, pcnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          lshift_q, lshift_d, rshift_q, rshift_d, ctrl_q, ctrl_d, alt_q, alt_d;
  logic          caps_q, caps_d, held_q, held_d;
  logic          key_valid_q, key_valid_d, key_extended_q, key_extended_d;
  logic          key_break_q, key_break_d, proto_err_q, proto_err_d;
  logic [7:0]    key_code_q, key_code_d, ascii_q, ascii_d;
  logic          ev, ev_ext, ev_brk, err;
  logic [7:0]    ev_code;

  // Letters come out uppercase from the table and are folded to lowercase here.
  function automatic logic [7:0] to_ascii(input logic [7:0] c, input logic up);
    logic [7:0] a;
    a = 8'h00;
    case (c)
      8'h1C: a = 8'h41; 8'h32: a = 8'h42; 8'h21: a = 8'h43; 8'h23: a = 8'h44;
      8'h24: a = 8'h45; 8'h2B: a = 8'h46; 8'h34: a = 8'h47; 8'h33: a = 8'h48;
      8'h43: a = 8'h49; 8'h3B: a = 8'h4A; 8'h42: a = 8'h4B; 8'h4B: a = 8'h4C;
      8'h3A: a = 8'h4D; 8'h31: a = 8'h4E; 8'h44: a = 8'h4F; 8'h4D: a = 8'h50;
      8'h15: a = 8'h51; 8'h2D: a = 8'h52; 8'h1B: a = 8'h53; 8'h2C: a = 8'h54;
      8'h3C: a = 8'h55; 8'h2A: a = 8'h56; 8'h1D: a = 8'h57; 8'h22: a = 8'h58;
      8'h35: a = 8'h59; 8'h1A: a = 8'h5A;
      8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
      8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
      8'h3E: a = 8'h38; 8'h46: a = 8'h39;
      8'h29: a = 8'h20; 8'h5A: a = 8'h0D; 8'h66: a = 8'h08;
      default: a = 8'h00;
    endcase
    return (a >= 8'h41 && !up) ? (a | 8'h20) : a;
  endfunction

  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    ev      = 1'b0;
    ev_code = rx_data;
    ev_ext  = 1'b0;
    ev_brk  = 1'b0;
    err     = 1'b0;
    if (rx_data_en) begin
      if (rx_data == 8'h00 || rx_data == 8'hFF) begin
        err     = 1'b1;
        state_d = IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (rx_data == 8'hE0) state_d = GOT_E0;
            else if (rx_data == 8'hF0) state_d = GOT_F0;
            else if (rx_data == 8'hE1) begin
              state_d = PAUSE;
              pcnt_d  = 3'd0;
            end else if (rx_data != 8'hAA && rx_data != 8'hFA) ev = 1'b1;
          end
          GOT_E0: begin
            if (rx_data == 8'hF0) state_d = GOT_E0F0;
            else if (rx_data != 8'hE0) begin
              ev      = 1'b1;
              ev_ext  = 1'b1;
              state_d = IDLE;
            end
          end
          GOT_F0: begin
            if (rx_data == 8'hE0 || rx_data == 8'hF0) begin
              err     = 1'b1;
              state_d = (rx_data == 8'hE0) ? GOT_E0 : GOT_F0;
            end else begin
              ev      = 1'b1;
              ev_brk  = 1'b1;
              state_d = IDLE;
            end
          end
          GOT_E0F0: begin
            err     = rx_data == 8'hE0 || rx_data == 8'hF0;
            ev      = !err;
            ev_ext  = 1'b1;
            ev_brk  = 1'b1;
            state_d = IDLE;
          end
          PAUSE: begin
            ev      = pcnt_q == 3'd6;
            ev_code = 8'hE1;
            pcnt_d  = pcnt_q + 3'd1;
            state_d = ev ? IDLE : PAUSE;
          end
          default: state_d = IDLE;
        endcase
      end
    end else if (state_q != IDLE && tmo_q == TMO) begin
      err     = 1'b1;
      state_d = IDLE;
    end
    tmo_d = (rx_data_en || state_d == IDLE) ? '0 : tmo_q + 1'b1;
  end

  always_comb begin
    lshift_d       = (ev && !ev_ext && ev_code == 8'h12) ? !ev_brk : lshift_q;
    rshift_d       = (ev && !ev_ext && ev_code == 8'h59) ? !ev_brk : rshift_q;
    ctrl_d         = (ev && ev_code == 8'h14) ? !ev_brk : ctrl_q;
    alt_d          = (ev && ev_code == 8'h11) ? !ev_brk : alt_q;
    caps_d         = (ev && !ev_ext && !ev_brk && ev_code == 8'h58 && !held_q) ? !caps_q : caps_q;
    held_d         = (ev && !ev_ext && ev_code == 8'h58) ? !ev_brk : held_q;
    key_valid_d    = ev;
    proto_err_d    = err;
    key_code_d     = ev ? ev_code : key_code_q;
    key_extended_d = ev ? ev_ext : key_extended_q;
    key_break_d    = ev ? ev_brk : key_break_q;
    ascii_d        = !ev ? ascii_q : (ev_ext || ev_brk) ? 8'h00 :
                     to_ascii(ev_code, (lshift_q | rshift_q) ^ caps_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      pcnt_q         <= '0;
      tmo_q          <= '0;
      lshift_q       <= 1'b0;
      rshift_q       <= 1'b0;
      ctrl_q         <= 1'b0;
      alt_q          <= 1'b0;
      caps_q         <= 1'b0;
      held_q         <= 1'b0;
      key_valid_q    <= 1'b0;
      key_code_q     <= '0;
      key_extended_q <= 1'b0;
      key_break_q    <= 1'b0;
      ascii_q        <= '0;
      proto_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      pcnt_q         <= pcnt_d;
      tmo_q          <= tmo_d;
      lshift_q       <= lshift_d;
      rshift_q       <= rshift_d;
      ctrl_q         <= ctrl_d;
      alt_q          <= alt_d;
      caps_q         <= caps_d;
      held_q         <= held_d;
      key_valid_q    <= key_valid_d;
      key_code_q     <= key_code_d;
      key_extended_q <= key_extended_d;
      key_break_q    <= key_break_d;
      ascii_q        <= ascii_d;
      proto_err_q    <= proto_err_d;
    end
  end

  assign key_valid    = key_valid_q;
  assign key_code     = key_code_q;
  assign key_extended = key_extended_q;
  assign key_break    = key_break_q;
  assign ascii        = ascii_q;
  assign mods         = {caps_q, alt_q, ctrl_q, lshift_q | rshift_q};
  assign proto_err    = proto_err_q;
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb_ps2_scancode_decoder: directed byte sequences with a queued scoreboard of expected events.
module tb_ps2_scancode_decoder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_data_en = 1'b0;
  logic       key_valid, key_extended, key_break, proto_err;
  logic [7:0] key_code, ascii;
  logic [3:0] mods;

  typedef struct {
    logic       err;
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [7:0] asc;
    logic [3:0] mods;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   passed = 0;

  ps2_scancode_decoder #(.TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_data_en(rx_data_en),
    .key_valid(key_valid), .key_code(key_code), .key_extended(key_extended),
    .key_break(key_break), .ascii(ascii), .mods(mods), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endtask

  task automatic exp_ev(input logic [7:0] c, input logic e, input logic b, input logic [7:0] a, input logic [3:0] m);
    q.push_back('{1'b0, c, e, b, a, m});
  endtask

  task automatic exp_err(input logic [3:0] m);
    q.push_back('{1'b1, 8'h00, 1'b0, 1'b0, 8'h00, m});
  endtask

  task automatic send(input logic [7:0] b);
    rx_data    = b;
    rx_data_en = 1'b1;
    @(posedge clk);
    #1;
    rx_data_en = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (q.size() != 0) begin
      total++;
      $display("FAIL %s: %0d expected outputs never appeared, required 0 pending", name, q.size());
      q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (key_valid || proto_err)) begin
      if (q.size() == 0) begin
        total++;
        $display("FAIL unexpected_output: got valid=%b err=%b code=%h, required no output",
                 key_valid, proto_err, key_code);
      end else begin
        e = q.pop_front();
        if (e.err)
          chk("proto_err", {8'h00, proto_err, key_valid, 18'h0, mods}, {8'h00, 2'b10, 18'h0, e.mods});
        else
          chk($sformatf("event_%h", e.code),
              {8'h00, proto_err, key_valid, key_code, key_extended, key_break, ascii, mods},
              {8'h00, 2'b01, e.code, e.ext, e.brk, e.asc, e.mods});
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {8'h00, key_valid, key_code, key_extended, key_break, ascii, mods, proto_err}, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    exp_ev(8'h1C, 0, 0, 8'h61, 4'b0000); send(8'h1C);
    send(8'hF0); exp_ev(8'h1C, 0, 1, 8'h00, 4'b0000); send(8'h1C);
    drain("press_release");

    exp_ev(8'h12, 0, 0, 8'h00, 4'b0001); send(8'h12);
    exp_ev(8'h1C, 0, 0, 8'h41, 4'b0001); send(8'h1C);
    send(8'hF0); exp_ev(8'h12, 0, 1, 8'h00, 4'b0000); send(8'h12);
    exp_ev(8'h58, 0, 0, 8'h00, 4'b1000); send(8'h58);
    exp_ev(8'h58, 0, 0, 8'h00, 4'b1000); send(8'h58);
    send(8'hF0); exp_ev(8'h58, 0, 1, 8'h00, 4'b1000); send(8'h58);
    exp_ev(8'h1C, 0, 0, 8'h41, 4'b1000); send(8'h1C);
    drain("shift_caps");
    chk("final_mods", {28'h0, mods}, 32'h8);

    send(8'hE0); exp_ev(8'h75, 1, 0, 8'h00, 4'b1000); send(8'h75);
    send(8'hE0); send(8'hF0); exp_ev(8'h75, 1, 1, 8'h00, 4'b1000); send(8'h75);
    drain("extended");

    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1); send(8'hF0); send(8'h14); send(8'hF0);
    exp_ev(8'hE1, 0, 0, 8'h00, 4'b1000); send(8'h77);
    exp_ev(8'h1C, 0, 0, 8'h41, 4'b1000); send(8'h1C);
    drain("pause");

    exp_err(4'b1000); send(8'hF0);
    drain("timeout");
    exp_ev(8'h1C, 0, 0, 8'h41, 4'b1000); send(8'h1C);
    drain("after_timeout");

    exp_err(4'b1000); send(8'hF0); exp_ev(8'h75, 1, 0, 8'h00, 4'b1000); send(8'hE0); send(8'h75);
    send(8'hAA); exp_ev(8'h29, 0, 0, 8'h20, 4'b1000); send(8'h29);
    drain("f0_e0_and_ignore");

    send(8'hF0); exp_err(4'b1000); send(8'h00);
    drain("zero_byte");
    send(8'hE0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_prefix_reset", {8'h00, key_valid, key_code, key_extended, key_break, ascii, mods, proto_err}, 32'h0);
    exp_ev(8'h1C, 0, 0, 8'h61, 4'b0000); send(8'h1C);
    drain("after_reset");

    exp_ev(8'h59, 0, 0, 8'h00, 4'b0001); send(8'h59);
    exp_ev(8'h16, 0, 0, 8'h31, 4'b0001); send(8'h16);
    exp_ev(8'h1A, 0, 0, 8'h5A, 4'b0001); send(8'h1A);
    send(8'hF0); exp_ev(8'h59, 0, 1, 8'h00, 4'b0000); send(8'h59);
    exp_ev(8'h14, 0, 0, 8'h00, 4'b0010); send(8'h14);
    send(8'hE0); exp_ev(8'h11, 1, 0, 8'h00, 4'b0110); send(8'h11);
    send(8'hE0); send(8'hF0); exp_ev(8'h14, 1, 1, 8'h00, 4'b0100); send(8'h14);
    exp_ev(8'h5A, 0, 0, 8'h0D, 4'b0100); send(8'h5A);
    drain("mods_digits");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
